// File: rtl/alu_adder_dmem.sv
// Execute/memory slice of a single-cycle MIPS datapath: ALU, standalone adder and
// word-organised data memory addressed by the ALU result.
module alu_adder_dmem #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALU_control,
  output logic [31:0] Out,
  output logic        Zero,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [31:0] add_res,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [31:0] writeData,
  output logic [31:0] readData
);

  logic [31:0]          alu_res;
  logic [31:0]          mem [MEM_WORDS];
  logic [ADDR_BITS-1:0] word_idx;

  always_comb begin
    alu_res = 32'd0;
    unique case (ALU_control)
      3'b000:  alu_res = A & B;
      3'b001:  alu_res = A | B;
      3'b010:  alu_res = A + B;
      3'b110:  alu_res = A - B;
      3'b111:  alu_res = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  assign Out     = alu_res;
  assign Zero    = (alu_res == 32'd0);
  assign add_res = add_a + add_b;

  // Byte offset and high address bits are dropped: misaligned accesses round down
  // and addresses alias modulo the memory size.
  assign word_idx = alu_res[ADDR_BITS+1:2];
  assign readData = memRead ? mem[word_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
    end else if (memWrite) begin
      mem[word_idx] <= writeData;
    end
  end

endmodule

// File: tb/tb_alu_adder_dmem.sv
// Directed-vector bench for alu_adder_dmem: ALU ops, adder wrap, memory write/read,
// aliasing and reset precedence.
module tb_alu_adder_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [2:0]  ALU_control;
  logic [31:0] Out;
  logic        Zero;
  logic [31:0] add_a, add_b, add_res;
  logic        memWrite, memRead;
  logic [31:0] writeData, readData;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_adder_dmem #(.MEM_WORDS(256), .ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALU_control(ALU_control),
    .Out(Out), .Zero(Zero), .add_a(add_a), .add_b(add_b), .add_res(add_res),
    .memWrite(memWrite), .memRead(memRead), .writeData(writeData), .readData(readData)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    A = a; B = b; ALU_control = op;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; ALU_control = 3'b010;
    add_a = '0; add_b = '0; memWrite = 1'b0; memRead = 1'b1; writeData = '0;
    edge_step();
    rst = 1'b0;

    alu(32'd0, 32'd8, 3'b010);
    chk("reset_rd8", readData, 32'd0);
    alu(32'd0, 32'd4, 3'b010);
    chk("reset_rd4", readData, 32'd0);

    alu(32'h0000_00F0, 32'h0000_0F0F, 3'b000);
    chk("and_out", Out, 32'h0);        chk("and_zero", {31'd0, Zero}, 32'd1);
    alu(32'h0000_00F0, 32'h0000_0F0F, 3'b001);
    chk("or_out", Out, 32'h0000_0FFF); chk("or_zero", {31'd0, Zero}, 32'd0);
    alu(32'h0000_00F0, 32'h0000_0F0F, 3'b010);
    chk("add_out", Out, 32'h0000_0FFF);
    alu(32'd5, 32'd5, 3'b110);
    chk("sub_out", Out, 32'h0);        chk("sub_zero", {31'd0, Zero}, 32'd1);
    alu(32'd3, 32'd5, 3'b110);
    chk("sub_neg", Out, 32'hFFFF_FFFE);
    alu(32'h7FFF_FFFF, 32'd1, 3'b010);
    chk("add_wrap", Out, 32'h8000_0000); chk("wrap_zero", {31'd0, Zero}, 32'd0);
    alu(32'hFFFF_FFFF, 32'd1, 3'b111);
    chk("slt_neg", Out, 32'd1);
    alu(32'd1, 32'hFFFF_FFFF, 3'b111);
    chk("slt_pos", Out, 32'd0);
    alu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
    chk("undef011", Out, 32'd0);       chk("undef_zero", {31'd0, Zero}, 32'd1);
    alu(32'hFFFF_FFFF, 32'h1234_5678, 3'b101);
    chk("undef101", Out, 32'd0);

    add_a = 32'h0040_0000; add_b = 32'd4; #1;
    chk("adder_pc4", add_res, 32'h0040_0004);
    add_a = 32'hFFFF_FFFC; add_b = 32'd8; #1;
    chk("adder_wrap", add_res, 32'h0000_0004);

    // Write 0xDEADBEEF to addr 8; old contents visible until the edge.
    alu(32'd0, 32'd8, 3'b010);
    writeData = 32'hDEAD_BEEF; memWrite = 1'b1; memRead = 1'b1; #1;
    chk("rw_before_edge", readData, 32'd0);
    edge_step();
    memWrite = 1'b0; #1;
    chk("rd_after_wr", readData, 32'hDEAD_BEEF);
    memRead = 1'b0; #1;
    chk("rd_disabled", readData, 32'd0);
    memRead = 1'b1;
    alu(32'h400, 32'hB, 3'b010);
    chk("alias_addr", Out, 32'h0000_040B);
    chk("alias_rd", readData, 32'hDEAD_BEEF);
    alu(32'd0, 32'd4, 3'b010);
    chk("rd4_untouched", readData, 32'd0);

    writeData = 32'h1234_5678; memWrite = 1'b1;
    edge_step();
    memWrite = 1'b0; #1;
    chk("rd4_written", readData, 32'h1234_5678);
    alu(32'd0, 32'd8, 3'b010);
    chk("rd8_kept", readData, 32'hDEAD_BEEF);

    // Reset wins over a simultaneous write.
    alu(32'd0, 32'd4, 3'b010);
    rst = 1'b1; memWrite = 1'b1; writeData = 32'hFFFF_FFFF;
    edge_step();
    rst = 1'b0; memWrite = 1'b0; #1;
    chk("rst_prec_rd4", readData, 32'd0);
    alu(32'd0, 32'd8, 3'b010);
    chk("rst_prec_rd8", readData, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
